alu_muldiv: RTL and testbench

Next-generation MIPS ALU, parametrised in datapath width N. It adds a multi-cycle iterative multiply/divide unit with architectural HI/LO registers. It also adds signed/unsigned compares, arithmetic shift, XOR and signed-overflow detection. It sits in the execute stage. Single-cycle ops are combinational; MULT/DIV use a start/busy/done handshake, and the hazard unit stalls on busy.

---
 rtl/alu_muldiv.sv | 181 ++++++++++++++++++
 tb/tb_alu_muldiv.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// Execute-stage ALU: single-cycle ops are combinational; MULT/DIV iterate one bit per cycle (busy N cycles, done 1 cycle).
// No backpressure path: start is only accepted in IDLE/DONE, and starts while busy are dropped (the hazard unit stalls on busy).
module alu_muldiv #(
  parameter int N  = 32,
  parameter int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  input  logic [4:0]    aluControl,
  input  logic [SW-1:0] shamt,
  input  logic          start,
  output logic [N-1:0]  aluResult,
  output logic          zero,
  output logic          overflow,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  hi,
  output logic [N-1:0]  lo
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_hi, r_lo;
  logic [N-1:0]  r_acc, r_mq, r_opb, r_a;
  logic          r_neg_q, r_neg_r, r_dz;
  logic          r_busy, r_done;

  logic [N-1:0]   w_sum, w_diff, w_result;
  logic           w_ovf, w_slt, w_sltu;
  logic           w_is_mul, w_is_div, w_signed, w_accept;
  logic           w_a_neg, w_b_neg;
  logic [N-1:0]   w_a_mag, w_b_mag;
  logic [N:0]     w_mul_sum, w_div_sh, w_div_trial;
  logic [N-1:0]   w_mul_acc, w_mul_mq, w_div_acc, w_div_mq;
  logic           w_div_ge;
  logic [2*N-1:0] w_prod, w_prod_s;
  logic [N-1:0]   w_quo, w_rem;

  assign w_sum  = a + b;
  assign w_diff = a - b;
  assign w_slt  = $signed(a) < $signed(b);
  assign w_sltu = a < b;

  always_comb begin
    w_result = a;
    w_ovf    = 1'b0;
    case (aluControl)
      5'd0: begin
        w_result = w_sum;
        w_ovf    = (a[N-1] == b[N-1]) && (w_sum[N-1] != a[N-1]);
      end
      5'd1: begin
        w_result = w_diff;
        w_ovf    = (a[N-1] != b[N-1]) && (w_diff[N-1] != a[N-1]);
      end
      5'd2:    w_result = a & b;
      5'd3:    w_result = a | b;
      5'd4:    w_result = ~(a | b);
      5'd5:    w_result = {{(N-1){1'b0}}, w_slt};
      5'd6:    w_result = b << shamt;
      5'd7:    w_result = b >> shamt;
      5'd8:    w_result = $signed(b) >>> shamt;
      5'd9:    w_result = {{(N-1){1'b0}}, w_sltu};
      5'd10:   w_result = a ^ b;
      5'd11:   w_result = r_hi;
      5'd12:   w_result = r_lo;
      default: w_result = a;
    endcase
  end

  assign aluResult = w_result;
  assign zero      = (w_result == '0);
  assign overflow  = w_ovf;
  assign busy      = r_busy;
  assign done      = r_done;
  assign hi        = r_hi;
  assign lo        = r_lo;

  assign w_is_mul = (aluControl == 5'd16) || (aluControl == 5'd17);
  assign w_is_div = (aluControl == 5'd18) || (aluControl == 5'd19);
  assign w_signed = (aluControl == 5'd16) || (aluControl == 5'd18);
  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // Both units iterate on magnitudes; signs are reapplied on the final edge.
  assign w_a_neg = w_signed && a[N-1];
  assign w_b_neg = w_signed && b[N-1];
  assign w_a_mag = w_a_neg ? -a : a;
  assign w_b_mag = w_b_neg ? -b : b;

  // Shift-add multiply: {r_acc, r_mq} holds partial product and remaining multiplier bits.
  assign w_mul_sum = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_opb} : {(N+1){1'b0}});
  assign w_mul_acc = w_mul_sum[N:1];
  assign w_mul_mq  = {w_mul_sum[0], r_mq[N-1:1]};

  // Restoring divide: r_acc is the partial remainder, r_mq shifts dividend out and quotient in.
  assign w_div_sh    = {r_acc, r_mq[N-1]};
  assign w_div_trial = w_div_sh - {1'b0, r_opb};
  assign w_div_ge    = ~w_div_trial[N];
  assign w_div_acc   = w_div_ge ? w_div_trial[N-1:0] : w_div_sh[N-1:0];
  assign w_div_mq    = {r_mq[N-2:0], w_div_ge};

  assign w_prod   = {w_mul_acc, w_mul_mq};
  assign w_prod_s = r_neg_q ? -w_prod : w_prod;
  assign w_quo    = r_neg_q ? -w_div_mq : w_div_mq;
  assign w_rem    = r_neg_r ? -w_div_acc : w_div_acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_acc   <= '0;
      r_mq    <= '0;
      r_opb   <= '0;
      r_a     <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          if (w_accept) begin
            if (aluControl == 5'd13) r_hi <= a;
            if (aluControl == 5'd14) r_lo <= a;
            if (w_is_mul || w_is_div) begin
              r_state <= w_is_mul ? S_MUL : S_DIV;
              r_busy  <= 1'b1;
              r_cnt   <= '0;
              r_acc   <= '0;
              r_mq    <= w_a_mag;
              r_opb   <= w_b_mag;
              r_a     <= a;
              r_neg_q <= w_a_neg ^ w_b_neg;
              r_neg_r <= w_a_neg;
              r_dz    <= (b == '0);
            end
          end
        end
        S_MUL, S_DIV: begin
          r_cnt <= r_cnt + CW'(1);
          if (r_state == S_MUL) begin
            r_acc <= w_mul_acc;
            r_mq  <= w_mul_mq;
          end else begin
            r_acc <= w_div_acc;
            r_mq  <= w_div_mq;
          end
          if (r_cnt == CW'(N-1)) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            if (r_state == S_MUL) begin
              r_hi <= w_prod_s[2*N-1:N];
              r_lo <= w_prod_s[N-1:0];
            end else if (r_dz) begin
              r_hi <= r_a;
              r_lo <= '1;
            end else begin
              r_hi <= w_rem;
              r_lo <= w_quo;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Table-driven bench for alu_muldiv (N=32): combinational vectors plus a scoreboard for MULT/DIV results.
module tb_alu_muldiv;
  localparam int N  = 32;
  localparam int SW = 5;

  logic          clk, reset, start;
  logic [N-1:0]  a, b, aluResult, hi, lo;
  logic [4:0]    aluControl;
  logic [SW-1:0] shamt;
  logic          zero, overflow, busy, done;

  alu_muldiv #(.N(N), .SW(SW)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .aluControl(aluControl),
    .shamt(shamt), .start(start), .aluResult(aluResult), .zero(zero),
    .overflow(overflow), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  ctl;
    logic [31:0] a, b;
    logic [4:0]  sh;
    logic [31:0] res;
    logic        z, o;
  } comb_vec_t;

  typedef struct {
    logic [4:0]  ctl;
    logic [31:0] a, b;
    logic [31:0] hi, lo;
  } seq_vec_t;

  typedef struct {
    logic [31:0] hi, lo;
  } exp_t;

  comb_vec_t cv[21];
  seq_vec_t  sv[11];
  exp_t      sb[$];
  int        n_cmp = 0;
  int        n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic launch(input logic [4:0] ctl, input logic [31:0] va, input logic [31:0] vb);
    @(posedge clk); #1;
    aluControl = ctl; a = va; b = vb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk(name, seen, 1'b1);
  endtask

  initial begin
    int   busy_cnt;
    exp_t e;
    busy_cnt = 0;
    reset = 1'b1; start = 1'b0; a = '0; b = '0; aluControl = 5'd0; shamt = '0;

    cv[0]  = '{5'd0,  32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 1'b0, 1'b1};
    cv[1]  = '{5'd1,  32'h00000005, 32'h00000005, 5'd0,  32'h00000000, 1'b1, 1'b0};
    cv[2]  = '{5'd1,  32'h80000000, 32'h00000001, 5'd0,  32'h7FFFFFFF, 1'b0, 1'b1};
    cv[3]  = '{5'd0,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 1'b1, 1'b0};
    cv[4]  = '{5'd0,  32'h80000000, 32'h80000000, 5'd0,  32'h00000000, 1'b1, 1'b1};
    cv[5]  = '{5'd1,  32'h7FFFFFFF, 32'hFFFFFFFF, 5'd0,  32'h80000000, 1'b0, 1'b1};
    cv[6]  = '{5'd2,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hF000F000, 1'b0, 1'b0};
    cv[7]  = '{5'd3,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hFFF0FFF0, 1'b0, 1'b0};
    cv[8]  = '{5'd4,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'h000F000F, 1'b0, 1'b0};
    cv[9]  = '{5'd10, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'h0FF00FF0, 1'b0, 1'b0};
    cv[10] = '{5'd5,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000001, 1'b0, 1'b0};
    cv[11] = '{5'd9,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 1'b1, 1'b0};
    cv[12] = '{5'd5,  32'h00000001, 32'hFFFFFFFF, 5'd0,  32'h00000000, 1'b1, 1'b0};
    cv[13] = '{5'd9,  32'h00000001, 32'hFFFFFFFF, 5'd0,  32'h00000001, 1'b0, 1'b0};
    cv[14] = '{5'd6,  32'h00000000, 32'h12345678, 5'd4,  32'h23456780, 1'b0, 1'b0};
    cv[15] = '{5'd6,  32'h00000000, 32'h00000001, 5'd31, 32'h80000000, 1'b0, 1'b0};
    cv[16] = '{5'd8,  32'h00000000, 32'h80000000, 5'd4,  32'hF8000000, 1'b0, 1'b0};
    cv[17] = '{5'd7,  32'h00000000, 32'h80000000, 5'd4,  32'h08000000, 1'b0, 1'b0};
    cv[18] = '{5'd8,  32'h00000000, 32'h7FFFFFFF, 5'd4,  32'h07FFFFFF, 1'b0, 1'b0};
    cv[19] = '{5'd11, 32'h12345678, 32'h00000000, 5'd0,  32'h00000000, 1'b1, 1'b0};
    cv[20] = '{5'd31, 32'hCAFEF00D, 32'h00000001, 5'd0,  32'hCAFEF00D, 1'b0, 1'b0};

    sv[0]  = '{5'd16, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    sv[1]  = '{5'd17, 32'hFFFFFFFD, 32'h00000005, 32'h00000004, 32'hFFFFFFF1};
    sv[2]  = '{5'd16, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    sv[3]  = '{5'd17, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    sv[4]  = '{5'd19, 32'd100,      32'd7,        32'h00000002, 32'h0000000E};
    sv[5]  = '{5'd18, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    sv[6]  = '{5'd18, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    sv[7]  = '{5'd18, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    sv[8]  = '{5'd19, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF};
    sv[9]  = '{5'd19, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
    sv[10] = '{5'd18, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};

    // Scoreboard side: every done pulse must match the oldest queued result and follow exactly N busy cycles.
    fork
      forever begin
        @(negedge clk);
        if (reset) begin
          busy_cnt = 0;
        end else begin
          if (busy) busy_cnt++;
          if (done) begin
            chk("busy_cycles", busy_cnt, N);
            busy_cnt = 0;
            chk("done_expected", (sb.size() != 0), 1'b1);
            if (sb.size() != 0) begin
              e = sb.pop_front();
              chk("hi_result", hi, e.hi);
              chk("lo_result", lo, e.lo);
            end
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1 aluControl = 5'd11;
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    @(posedge clk); #1 reset = 1'b0;

    foreach (cv[i]) begin
      @(posedge clk); #1;
      aluControl = cv[i].ctl; a = cv[i].a; b = cv[i].b; shamt = cv[i].sh;
      @(negedge clk);
      chk($sformatf("comb_res[%0d]", i), aluResult, cv[i].res);
      chk($sformatf("comb_zero[%0d]", i), zero, cv[i].z);
      chk($sformatf("comb_ovf[%0d]", i), overflow, cv[i].o);
    end

    foreach (sv[i]) begin
      sb.push_back('{sv[i].hi, sv[i].lo});
      launch(sv[i].ctl, sv[i].a, sv[i].b);
      wait_done($sformatf("done_seen[%0d]", i));
    end

    // Interference while busy: old hi/lo visible, DIV start and MTLO dropped, operand changes ignored.
    sb.push_back('{32'h0, 32'd42});
    launch(5'd16, 32'd6, 32'd7);
    repeat (3) @(posedge clk);
    #1 aluControl = 5'd12;
    @(negedge clk);
    chk("mflo_busy", aluResult, 32'hFFFFFFFF);
    #1 aluControl = 5'd11;
    @(negedge clk);
    chk("mfhi_busy", aluResult, 32'hFFFFFFF9);
    repeat (5) @(posedge clk);
    launch(5'd18, 32'd100, 32'd7);
    launch(5'd14, 32'h1234, 32'd0);
    @(negedge clk);
    chk("busy_after_ignored", busy, 1'b1);
    chk("lo_mtlo_busy", lo, 32'hFFFFFFFF);
    wait_done("done_mult_interf");

    @(posedge clk);
    launch(5'd14, 32'h1234, 32'd0);
    @(negedge clk);
    chk("mtlo_idle", lo, 32'h1234);
    chk("mtlo_no_busy", busy, 1'b0);
    launch(5'd13, 32'hABCD, 32'd0);
    @(negedge clk);
    chk("mthi_idle", hi, 32'hABCD);
    launch(5'd15, 32'h5555, 32'd0);
    @(negedge clk);
    chk("rsvd_hi", hi, 32'hABCD);
    chk("rsvd_lo", lo, 32'h1234);
    chk("rsvd_busy", busy, 1'b0);
    #1 aluControl = 5'd12;
    @(negedge clk);
    chk("mflo_idle", aluResult, 32'h1234);

    // Reset in the middle of a DIV discards it; a fresh MULT runs normally afterwards.
    sb.push_back('{32'd2, 32'd14});
    launch(5'd19, 32'd100, 32'd7);
    repeat (14) @(posedge clk);
    #1 reset = 1'b1;
    sb.delete();
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_hi", hi, 32'h0);
    chk("midrst_lo", lo, 32'h0);
    sb.push_back('{32'h0, 32'd6});
    launch(5'd16, 32'd2, 32'd3);
    wait_done("done_after_rst");
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
